// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO register-target slice.
package pio_pkg;

    localparam int unsigned PIO_ADDR_W = 16;
    localparam int unsigned PIO_DATA_W = 32;
    localparam int unsigned ERR_CNT_W  = 16;

    // Offsets of the special registers, relative to the number of CTRL registers.
    localparam int unsigned STATUS_REL  = 0;
    localparam int unsigned ERR_CNT_REL = 1;

    typedef struct packed {
        logic                  vld;
        logic                  rw;
        logic [PIO_ADDR_W-1:0] addr;
        logic [PIO_DATA_W-1:0] data_w;
    } pio_cmd_t;

    function automatic logic [PIO_ADDR_W-1:0] status_ofs(input int unsigned num_regs);
        return PIO_ADDR_W'(num_regs + STATUS_REL);
    endfunction

    function automatic logic [PIO_ADDR_W-1:0] err_cnt_ofs(input int unsigned num_regs);
        return PIO_ADDR_W'(num_regs + ERR_CNT_REL);
    endfunction

endpackage

// File: rtl/pio_if.sv
// PIO bus segment: command from initiator, read response from target.
interface pio_if;
    import pio_pkg::*;

    logic                  cmd_vld;
    logic                  rw;
    logic [PIO_ADDR_W-1:0] addr;
    logic [PIO_DATA_W-1:0] data_w;
    logic [PIO_DATA_W-1:0] data_r;
    logic                  rd_vld;

    modport master (
        output cmd_vld, rw, addr, data_w,
        input  data_r, rd_vld
    );

    modport slave (
        input  cmd_vld, rw, addr, data_w,
        output data_r, rd_vld
    );

endinterface

// File: rtl/pio_rd_pipe.sv
// Fixed-latency valid/data delay line for read responses, with synchronous flush.
module pio_rd_pipe
    import pio_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_flush,
    input  logic                  i_vld,
    input  logic [PIO_DATA_W-1:0] i_data,
    output logic                  o_vld,
    output logic [PIO_DATA_W-1:0] o_data
);

    logic [RD_LATENCY-1:0] r_vld;
    logic [PIO_DATA_W-1:0] r_data [RD_LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_vld <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            // Data is zeroed when not valid so the output never shows stale values.
            r_data[0] <= i_vld ? i_data : '0;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_vld  = r_vld[RD_LATENCY-1];
    assign o_data = r_data[RD_LATENCY-1];

endmodule

// File: rtl/pio_reg_target.sv
// PIO register-bank target: CTRL registers, read-only STATUS and a saturating
// error counter, with fixed-latency pipelined read responses.
module pio_reg_target
    import pio_pkg::*;
#(
    parameter logic [PIO_ADDR_W-1:0] BASE_ADDR  = 16'h0100,
    parameter int unsigned           NUM_REGS   = 8,
    parameter int unsigned           RD_LATENCY = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    pio_if.slave                           io_pio,
    input  logic [PIO_DATA_W-1:0]          i_status_in,
    output logic [NUM_REGS*PIO_DATA_W-1:0] o_regs_out
);

    pio_cmd_t              w_cmd;
    logic [PIO_ADDR_W-1:0] w_offset;
    logic                  w_hit;
    logic                  w_wr;
    logic                  w_rd;
    logic [PIO_DATA_W-1:0] w_rd_data;

    logic [PIO_DATA_W-1:0] r_ctrl [NUM_REGS];
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    assign w_cmd = '{vld: io_pio.cmd_vld, rw: io_pio.rw, addr: io_pio.addr,
                     data_w: io_pio.data_w};

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign w_offset = w_cmd.addr - BASE_ADDR;
    assign w_hit    = w_cmd.vld && i_reset && (w_offset <= err_cnt_ofs(NUM_REGS));
    assign w_wr     = w_hit && w_cmd.rw;
    assign w_rd     = w_hit && !w_cmd.rw;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_ctrl[i] <= '0;
            end
            r_err_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_wr && (w_offset == PIO_ADDR_W'(i))) begin
                    r_ctrl[i] <= w_cmd.data_w;
                end
            end
            if (w_wr && (w_offset == err_cnt_ofs(NUM_REGS))) begin
                r_err_cnt <= '0;
            end else if (w_wr && (w_offset == status_ofs(NUM_REGS)) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_offset == PIO_ADDR_W'(i)) begin
                w_rd_data = r_ctrl[i];
            end
        end
        if (w_offset == status_ofs(NUM_REGS)) begin
            w_rd_data = i_status_in;
        end
        if (w_offset == err_cnt_ofs(NUM_REGS)) begin
            w_rd_data = {{(PIO_DATA_W-ERR_CNT_W){1'b0}}, r_err_cnt};
        end
    end

    pio_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_flush (!i_reset),
        .i_vld   (w_rd),
        .i_data  (w_rd_data),
        .o_vld   (io_pio.rd_vld),
        .o_data  (io_pio.data_r)
    );

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
        assign o_regs_out[g*PIO_DATA_W +: PIO_DATA_W] = r_ctrl[g];
    end

endmodule

// File: tb/tb_pio_reg_target.sv
// Randomised bench: three targets (latency 1, 2, 4) share one stimulus stream and are
// compared each cycle against a register-map model with per-latency response queues.
module tb_pio_reg_target;
    import pio_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data_w;
    logic [31:0] status;

    logic [255:0] regs_l1, regs_l2, regs_l4;
    logic         got_vld  [3];
    logic [31:0]  got_data [3];
    logic [255:0] got_regs [3];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   [3] = '{1, 2, 4};
    logic [31:0] m_ctrl [8];
    int unsigned m_err;
    rsp_t        m_q   [3][$];

    always #5 clk = ~clk;

    pio_if bus_l1 ();
    pio_if bus_l2 ();
    pio_if bus_l4 ();

    assign bus_l1.cmd_vld = cmd_vld;
    assign bus_l1.rw      = rw;
    assign bus_l1.addr    = addr;
    assign bus_l1.data_w  = data_w;
    assign bus_l2.cmd_vld = cmd_vld;
    assign bus_l2.rw      = rw;
    assign bus_l2.addr    = addr;
    assign bus_l2.data_w  = data_w;
    assign bus_l4.cmd_vld = cmd_vld;
    assign bus_l4.rw      = rw;
    assign bus_l4.addr    = addr;
    assign bus_l4.data_w  = data_w;

    assign got_vld[0]  = bus_l1.rd_vld;
    assign got_vld[1]  = bus_l2.rd_vld;
    assign got_vld[2]  = bus_l4.rd_vld;
    assign got_data[0] = bus_l1.data_r;
    assign got_data[1] = bus_l2.data_r;
    assign got_data[2] = bus_l4.data_r;
    assign got_regs[0] = regs_l1;
    assign got_regs[1] = regs_l2;
    assign got_regs[2] = regs_l4;

    pio_reg_target #(.BASE_ADDR(16'h0100), .NUM_REGS(8), .RD_LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_reset(rst_n), .io_pio(bus_l1), .i_status_in(status),
        .o_regs_out(regs_l1)
    );
    pio_reg_target #(.BASE_ADDR(16'h0100), .NUM_REGS(8), .RD_LATENCY(2)) u_dut_l2 (
        .i_clk(clk), .i_reset(rst_n), .io_pio(bus_l2), .i_status_in(status),
        .o_regs_out(regs_l2)
    );
    pio_reg_target #(.BASE_ADDR(16'h0100), .NUM_REGS(8), .RD_LATENCY(4)) u_dut_l4 (
        .i_clk(clk), .i_reset(rst_n), .io_pio(bus_l4), .i_status_in(status),
        .o_regs_out(regs_l4)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Apply the command edge to the register-map model.
    task automatic model_edge();
        logic [15:0]  off;
        logic [31:0]  val;
        off = addr - 16'h0100;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_ctrl[i] = '0;
            m_err = 0;
            for (int k = 0; k < 3; k++) m_q[k].delete();
        end else if (cmd_vld && off <= 16'd9) begin
            if (rw) begin
                if (off < 16'd8)       m_ctrl[off] = data_w;
                else if (off == 16'd8) m_err = (m_err == 32'hFFFF) ? m_err : m_err + 1;
                else                   m_err = 0;
            end else begin
                if (off < 16'd8)       val = m_ctrl[off];
                else if (off == 16'd8) val = status;
                else                   val = m_err;
                for (int k = 0; k < 3; k++) m_q[k].push_back('{due: cyc + lat[k] - 1, d: val});
            end
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [15:0] a,
                        input logic [31:0] d);
        logic         exp_v;
        logic [31:0]  exp_d;
        logic [255:0] exp_regs;
        cmd_vld = v;
        rw      = w;
        addr    = a;
        data_w  = d;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        for (int i = 0; i < 8; i++) exp_regs[i*32 +: 32] = m_ctrl[i];
        for (int k = 0; k < 3; k++) begin
            exp_v = (m_q[k].size() > 0) && (m_q[k][0].due == cyc);
            exp_d = exp_v ? m_q[k][0].d : 32'h0;
            if (exp_v) void'(m_q[k].pop_front());
            check($sformatf("rd_vld_L%0d", lat[k]), 256'(got_vld[k]), 256'(exp_v));
            check($sformatf("data_r_L%0d", lat[k]), 256'(got_data[k]), 256'(exp_d));
            check($sformatf("regs_out_L%0d", lat[k]), got_regs[k], exp_regs);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        status  = 32'h0;
        cmd_vld = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data_w  = '0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Write then immediate read-back.
        step(1'b1, 1'b1, 16'h0103, 32'hDEADBEEF);
        step(1'b1, 1'b0, 16'h0103, 32'h0);
        idle(5);

        // Back-to-back reads return in order.
        step(1'b1, 1'b1, 16'h0100, 32'd1);
        step(1'b1, 1'b1, 16'h0101, 32'd2);
        step(1'b1, 1'b1, 16'h0102, 32'd3);
        step(1'b1, 1'b0, 16'h0100, 32'h0);
        step(1'b1, 1'b0, 16'h0101, 32'h0);
        step(1'b1, 1'b0, 16'h0102, 32'h0);
        idle(5);

        // Out-of-window accesses are ignored.
        step(1'b1, 1'b0, 16'h00FF, 32'h0);
        step(1'b1, 1'b0, 16'h010A, 32'h0);
        step(1'b1, 1'b1, 16'h0200, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 16'h0109, 32'h0);
        idle(5);

        // STATUS writes count errors; ERR_CNT write clears.
        status = 32'h5A5A0001;
        step(1'b1, 1'b1, 16'h0108, 32'h1);
        step(1'b1, 1'b1, 16'h0108, 32'h2);
        step(1'b1, 1'b1, 16'h0108, 32'h3);
        step(1'b1, 1'b0, 16'h0109, 32'h0);
        step(1'b1, 1'b0, 16'h0108, 32'h0);
        step(1'b1, 1'b1, 16'h0109, 32'h1234_5678);
        step(1'b1, 1'b0, 16'h0109, 32'h0);
        idle(5);

        // Reset with reads in flight drops them; CTRL reads back zero.
        step(1'b1, 1'b0, 16'h0103, 32'h0);
        step(1'b1, 1'b0, 16'h0100, 32'h0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 16'h0101, 32'h0);
        rst_n = 1'b1;
        idle(5);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 32'h0);
        idle(5);

        // Saturation: counter sticks at FFFF, including on further STATUS writes.
        for (int i = 0; i < 65536; i++) step(1'b1, 1'b1, 16'h0108, 32'h0);
        step(1'b1, 1'b0, 16'h0109, 32'h0);
        step(1'b1, 1'b1, 16'h0108, 32'h0);
        step(1'b1, 1'b0, 16'h0109, 32'h0);
        idle(5);

        // Random traffic across and around the window, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            status = $urandom;
            rst_n  = ($urandom_range(0, 59) != 0);
            a      = ($urandom_range(0, 15) == 0) ? 16'h0200
                                                  : 16'h00FD + 16'($urandom_range(0, 14));
            step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), a, $urandom);
        end
        rst_n = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
